// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding,
// default geometry and the iteration-counter width helper.
package div_pkg;

  localparam int W_DEF   = 32;
  localparam int BPC_DEF = 1;
  localparam int N       = W_DEF / BPC_DEF;

  // A single-iteration configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and retire one quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] lo_o
);

  logic [W:0] trial;
  logic       ge;

  assign trial = {rem_i, lo_i[W-1]};
  assign ge    = trial >= {1'b0, d_i};
  // The remainder stays below d, so the difference always fits in W bits.
  assign rem_o = ge ? W'(trial - {1'b0, d_i}) : trial[W-1:0];
  assign lo_o  = {lo_i[W-2:0], ge};

endmodule

// File: rtl/div_iter.sv
// Iterative 2W/W restoring divider, BPC quotient bits per clock, with signed
// mode, divide-by-zero / overflow flags and valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for an op; in_ready high
// RUN   | N iterations of BPC restoring steps in flight
// DONE  | result held on q/r/flags until out_ready
module div_iter
  import div_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int BPC = BPC_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [2*W-1:0] x,
  input  logic [W-1:0]   d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           div_zero,
  output logic           ovf
);

  localparam int NI = W / BPC;
  localparam int CW = cnt_width(NI);
  localparam logic [CW-1:0] CNT_LAST = CW'(NI - 1);

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   dmag_q, rem_q, lo_q;
  logic           sgn_q, neg_q_q, neg_r_q;
  logic [W-1:0]   q_q, r_q;
  logic           dz_q, ovf_q, in_ready_q, out_valid_q;

  logic           sx, sd;
  logic [2*W-1:0] xmag;
  logic [W-1:0]   dmag;
  logic           acc_ovf;

  assign sx      = in_signed & x[2*W-1];
  assign sd      = in_signed & d[W-1];
  assign xmag    = sx ? -x : x;
  assign dmag    = sd ? -d : d;
  // High half >= divisor means the quotient cannot fit in W bits.
  assign acc_ovf = xmag[2*W-1:W] >= dmag;

  logic [W-1:0] rem_c [BPC+1];
  logic [W-1:0] lo_c  [BPC+1];

  assign rem_c[0] = rem_q;
  assign lo_c[0]  = lo_q;

  for (genvar gi = 0; gi < BPC; gi++) begin : g_step
    div_step #(.W(W)) u_step (
      .rem_i (rem_c[gi]),
      .lo_i  (lo_c[gi]),
      .d_i   (dmag_q),
      .rem_o (rem_c[gi+1]),
      .lo_o  (lo_c[gi+1])
    );
  end

  logic [W-1:0] qmag, rmag, q_d, r_d;
  logic         run_ovf;

  assign qmag    = lo_c[BPC];
  assign rmag    = rem_c[BPC];
  // Signed range is [-2^(W-1), 2^(W-1)-1]; only the negative side reaches 2^(W-1).
  assign run_ovf = sgn_q & qmag[W-1] & (~neg_q_q | (|qmag[W-2:0]));
  assign q_d     = run_ovf ? '1 : (neg_q_q ? -qmag : qmag);
  assign r_d     = run_ovf ? '0 : (neg_r_q ? -rmag : rmag);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dmag_q      <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      sgn_q       <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sgn_q      <= in_signed;
            neg_q_q    <= sx ^ sd;
            neg_r_q    <= sx;
            dmag_q     <= dmag;
            rem_q      <= xmag[2*W-1:W];
            lo_q       <= xmag[W-1:0];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (d == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dz_q        <= 1'b1;
              ovf_q       <= 1'b0;
              q_q         <= '1;
              r_q         <= x[W-1:0];
            end else if (acc_ovf) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dz_q        <= 1'b0;
              ovf_q       <= 1'b1;
              q_q         <= '1;
              r_q         <= '0;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_c[BPC];
          lo_q  <= lo_c[BPC];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            dz_q        <= 1'b0;
            ovf_q       <= run_ovf;
            q_q         <= q_d;
            r_q         <= r_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: two instances (BPC=1 and BPC=4) checked against an
// arithmetic reference model, plus directed latency/handshake/reset cases.
module tb_div_iter;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] x = '0;
  logic [31:0] d = '0;
  logic        sgn = 1'b0;

  logic        in_valid [2];
  logic        out_ready[2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic        dz       [2];
  logic        ovf      [2];
  logic [31:0] q        [2];
  logic [31:0] r        [2];

  int n_tot = 0;
  int n_pass = 0;

  res_t exp0[$];
  res_t exp1[$];

  always #5 clk = ~clk;

  div_iter #(.W(32), .BPC(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_signed(sgn), .x(x), .d(d), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .q(q[0]), .r(r[0]), .div_zero(dz[0]), .ovf(ovf[0])
  );

  div_iter #(.W(32), .BPC(4)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_signed(sgn), .x(x), .d(d), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .q(q[1]), .r(r[1]), .div_zero(dz[1]), .ovf(ovf[1])
  );

  // Reference: divide magnitudes with plain 64-bit arithmetic, then apply
  // truncation-toward-zero signs and the W-bit range rules.
  function automatic res_t model(input logic [63:0] xv, input logic [31:0] dv, input logic sg);
    res_t        res;
    logic [63:0] xm, qm, rm;
    logic [31:0] dm, q32, r32;
    logic        nq, nr, of;
    res = '0;
    if (dv == 32'd0) begin
      res.dz = 1'b1;
      res.q  = 32'hFFFF_FFFF;
      res.r  = xv[31:0];
      return res;
    end
    nr = sg && xv[63];
    nq = nr ^ (sg && dv[31]);
    xm = nr ? -xv : xv;
    dm = (sg && dv[31]) ? -dv : dv;
    qm = xm / {32'd0, dm};
    rm = xm % {32'd0, dm};
    if (!sg)     of = qm > 64'hFFFF_FFFF;
    else if (nq) of = qm > 64'h8000_0000;
    else         of = qm >= 64'h8000_0000;
    if (of) begin
      res.ovf = 1'b1;
      res.q   = 32'hFFFF_FFFF;
      res.r   = 32'd0;
    end else begin
      q32   = qm[31:0];
      r32   = rm[31:0];
      res.q = nq ? -q32 : q32;
      res.r = nr ? -r32 : r32;
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_tot++;
    $display("FAIL timeout %s: condition not reached within 300 cycles", nm);
  endtask

  // Compare process: every cycle a result is presented it must equal the
  // oldest accepted op's model result.
  always @(negedge clk) begin
    res_t e;
    if (!rstn) begin
      exp0.delete();
      exp1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          if (i == 0) exp0.push_back(model(x, d, sgn));
          else        exp1.push_back(model(x, d, sgn));
        end
        if (out_valid[i]) begin
          if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
            n_tot++;
            $display("FAIL unexpected_valid%0d: got out_valid=1 expected no pending op", i);
          end else begin
            e = (i == 0) ? exp0[0] : exp1[0];
            chk($sformatf("result%0d", i), {q[i], r[i], dz[i], ovf[i]}, e);
            if (out_ready[i]) begin
              if (i == 0) void'(exp0.pop_front());
              else        void'(exp1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic start_op(input int inst, input logic [63:0] xv, input logic [31:0] dv, input logic sg);
    int n = 0;
    while (!in_ready[inst]) begin
      if (n >= 300) begin
        timeout_fail("in_ready");
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    x = xv;
    d = dv;
    sgn = sg;
    in_valid[inst] = 1'b1;
    @(posedge clk); #1;
    in_valid[inst] = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid is seen
  task automatic wait_valid(input int inst, output int lat);
    lat = 0;
    while (!out_valid[inst]) begin
      if (lat >= 300) begin
        timeout_fail("out_valid");
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(input int inst, input bit rnd);
    int n = 0;
    do begin
      out_ready[inst] = (!rnd || n > 20) ? 1'b1 : 1'($urandom % 2);
      @(posedge clk); #1;
      n++;
    end while (!out_ready[inst]);
    out_ready[inst] = 1'b0;
  endtask

  task automatic dir_op(input int inst, input string nm, input logic [63:0] xv,
                        input logic [31:0] dv, input logic sg, input res_t e, input int elat);
    int lat;
    start_op(inst, xv, dv, sg);
    wait_valid(inst, lat);
    chk(nm, {q[inst], r[inst], dz[inst], ovf[inst]}, e);
    chk({nm, "_lat"}, lat, elat);
    take(inst, 1'b0);
  endtask

  task automatic gen(output logic [63:0] xv, output logic [31:0] dv, output logic sg);
    logic [31:0] dm, hi;
    int sel;
    sg  = 1'($urandom % 2);
    sel = $urandom % 10;
    dm  = $urandom >> ($urandom % 32);
    if (dm == 0) dm = 1;
    if (sel == 0) begin
      xv = {$urandom, $urandom};
      dv = 32'd0;
    end else if (sel == 1) begin
      xv = {$urandom, $urandom};
      dv = $urandom;
    end else begin
      hi = $urandom % dm;
      if (sg) hi = hi >> 1;
      xv = {hi, $urandom};
      if (sg && ($urandom % 2 == 1)) xv = -xv;
      dv = (sg && ($urandom % 2 == 1)) ? -dm : dm;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_tot + 1);
    $fatal(1);
  end

  initial begin
    logic [63:0] xv;
    logic [31:0] dv;
    logic        sg;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end

    // model pins
    chk("model_pin_u", model(64'd100, 32'd7, 1'b0), {32'd14, 32'd2, 1'b0, 1'b0});
    chk("model_pin_sneg", model(-64'sd7, 32'd2, 1'b1), {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0});
    chk("model_pin_sdneg", model(64'd7, 32'hFFFF_FFFE, 1'b1), {32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset0", {in_ready[0], out_valid[0], q[0], r[0], dz[0], ovf[0]}, {1'b1, 1'b0, 64'd0, 2'b00});
    chk("reset1", {in_ready[1], out_valid[1], q[1], r[1], dz[1], ovf[1]}, {1'b1, 1'b0, 64'd0, 2'b00});
    rstn = 1'b1;
    @(posedge clk); #1;

    dir_op(0, "u100_7", 64'd100, 32'd7, 1'b0, {32'd14, 32'd2, 1'b0, 1'b0}, 32);
    dir_op(0, "divzero", 64'h1234, 32'd0, 1'b0, {32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0}, 0);
    dir_op(0, "ovf_u", 64'h1_0000_0000, 32'd1, 1'b0, {32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1}, 0);
    dir_op(0, "ovf_s", 64'h8000_0000, 32'd1, 1'b1, {32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1}, 32);
    dir_op(0, "s_min", 64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1, {32'h8000_0000, 32'd0, 1'b0, 1'b0}, 32);
    dir_op(0, "s_neg7", 64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0}, 32);
    dir_op(0, "s_7_neg2", 64'd7, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0}, 32);
    dir_op(1, "bpc4_u100_7", 64'd100, 32'd7, 1'b0, {32'd14, 32'd2, 1'b0, 1'b0}, 8);

    // backpressure: result must hold while out_ready is low
    start_op(0, 64'd100, 32'd7, 1'b0);
    wait_valid(0, lat);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid[0], in_ready[0], q[0], r[0]}, {1'b1, 1'b0, 32'd14, 32'd2});
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_release", {out_valid[0], in_ready[0]}, 2'b01);

    // reset in the middle of RUN discards the op
    start_op(0, 64'h0000_1234_9ABC_DEF0, 32'h1357_9BDF, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid", {out_valid[0], in_ready[0], q[0], r[0], dz[0], ovf[0]}, {1'b0, 1'b1, 64'd0, 2'b00});
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_after", {out_valid[0], in_ready[0]}, 2'b01);

    for (int k = 0; k < 1200; k++) begin
      gen(xv, dv, sg);
      start_op(0, xv, dv, sg);
      wait_valid(0, lat);
      take(0, 1'b1);
    end
    for (int k = 0; k < 800; k++) begin
      gen(xv, dv, sg);
      start_op(1, xv, dv, sg);
      wait_valid(1, lat);
      take(1, 1'b1);
    end

    @(posedge clk); #1;
    chk("drain", {32'(exp0.size()), 32'(exp1.size())}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
